pciea_ext_cq_credit_rx: RTL and testbench
=========================================

Name: pciea_ext_cq_credit_rx

Overview:
Receiving (slave) end of the credit-based PCIe completer-request stream (the `pciea_port_axis_ext_cq_if` `s` side). Buffers incoming CQ beats and presents them downstream as a plain valid/ready AXI-Stream. Returns one credit pulse per buffer slot freed. Sits between the CPM CQ port and user CQ logic, so the hard block never needs tready.

Parameters:
DEPTH, 16, beat buffer entries; power of two, >=2; equals total credits advertised.
DATA_WIDTH, 512, tdata width.
USER_WIDTH, 229, tuser width.
KEEP_WIDTH, DATA_WIDTH/32, tkeep width (dword granularity).

Ports:
user_clk  in  1  sole clock.
user_reset  in  1  asynchronous, active-high reset.
s_axis_cq_tdata  in  DATA_WIDTH  upstream beat data.
s_axis_cq_tuser  in  USER_WIDTH  upstream sideband.
s_axis_cq_tlast  in  1  end of TLP.
s_axis_cq_tkeep  in  KEEP_WIDTH  dword enables.
s_axis_cq_tvalid  in  1  beat present; no ready, always accepted.
s_axis_cq_credit  out  1  one-cycle pulse = one beat credit granted upstream.
m_axis_cq_tdata  out  DATA_WIDTH  downstream data.
m_axis_cq_tuser  out  USER_WIDTH  downstream sideband.
m_axis_cq_tlast  out  1  downstream tlast.
m_axis_cq_tkeep  out  KEEP_WIDTH  downstream tkeep.
m_axis_cq_tvalid  out  1  downstream valid.
m_axis_cq_tready  in  1  downstream ready.
credit_outstanding  out  $clog2(DEPTH)+1  credits granted but not yet consumed.
fifo_level  out  $clog2(DEPTH)+1  beats held.
err_overflow  out  1  sticky; beat arrived with zero outstanding credit.

Behaviour:
- Reset is asynchronous, active-high.
- Reset values of outputs: s_axis_cq_credit=0, m_axis_cq_tvalid=0, m_axis_cq_* data fields=0, credit_outstanding=0, fifo_level=0, err_overflow=0.
- Reset values of internal state: pending_return=DEPTH, FIFO pointers=0.
- One credit is one beat, regardless of tlast or tkeep.
- Credit return, every cycle:
  - If pending_return>0, assert s_axis_cq_credit (registered), decrement pending_return, increment credit_outstanding.
  - At most one credit per cycle.
  - After reset deassert, DEPTH pulses issue on consecutive cycles, starting the first user_clk edge after deassert.
- Ingress:
  - s_axis_cq_tvalid with credit_outstanding>0: write the beat to the FIFO tail and decrement credit_outstanding.
  - s_axis_cq_tvalid with credit_outstanding==0: drop the beat, set err_overflow. No state change otherwise.
- Egress:
  - The FIFO is first-word-fall-through; a beat written in cycle N shows m_axis_cq_tvalid=1 in cycle N+1.
  - A pop occurs when m_axis_cq_tvalid && m_axis_cq_tready.
  - On pop, increment pending_return. The credit pulse appears no earlier than the cycle after the pop.
  - m_axis_cq_* outputs are held stable while tvalid=1 and tready=0.
- Simultaneous events:
  - Pop + credit issue in the same cycle: pending_return unchanged.
  - Write + credit issue in the same cycle: credit_outstanding unchanged.
  - Write + pop in the same cycle: fifo_level unchanged. This is legal when full (pop frees the slot first only logically; the credit invariant prevents a write into a truly full FIFO).
- Invariant: fifo_level + credit_outstanding + pending_return == DEPTH at all times, except transiently on a dropped overflow beat, which leaves it unchanged. Verification asserts this.
- Pointer wrap: pointers are $clog2(DEPTH)+1 bits. Full when the MSBs differ and the LSBs are equal; empty when all bits are equal.
- Reset mid-operation:
  - The FIFO is flushed and all in-flight beats are lost.
  - Credit re-advertisement restarts at DEPTH.
  - The upstream peer must be reset concurrently.
- No TLP-level awareness: tlast is carried only.
- No backpressure exists upstream.

Decomposition:
- Package `cpm_ext_cq_pkg` holds:
  - localparam `CQ_EXT_USER_W` = 229.
  - typedef `cq_beat_t`, a packed struct {tdata, tuser, tlast, tkeep}.
  - function `clog2_cnt_w(DEPTH)`.
- Sub-module `cpm_cq_beat_fifo`: synchronous FWFT FIFO of `cq_beat_t`, DEPTH entries, with wr_en/rd_en/full/empty/level.
- The credit counters and error logic live in the top level.

Test Plan:
- Reset release, no traffic -> exactly 16 credit pulses on cycles 1..16 after deassert; then credit_outstanding=16 and no further pulses.
- Single beat (tdata=0xA5.., tlast=1, tkeep=16'hFFFF) with tready=1 -> m_tvalid in cycle N+1 with identical fields; one credit pulse in cycle N+2; credit_outstanding returns to 16.
- 16 back-to-back beats with tready=0 -> fifo_level=16, credit_outstanding=0, no credits issued. Then tready=1 -> 16 beats out in order, followed by 16 credit pulses, one cycle after each pop.
- 17th beat sent while credit_outstanding==0 -> beat dropped, err_overflow=1 (sticky), fifo_level stays 16, the invariant still holds.
- Random tvalid (50%) and random tready (30%) over 10k beats -> output sequence equals input sequence, no overflow, the invariant holds every cycle.
- user_reset asserted mid-burst with fifo_level=7 -> all outputs zero immediately; after deassert, 16 fresh credit pulses and an empty FIFO.

Source files
------------

// File: rtl/cpm_ext_cq_pkg.sv
// Shared types and helpers for the external CQ credit receiver.
package cpm_ext_cq_pkg;

  localparam int unsigned CQ_EXT_USER_W = 229;
  localparam int unsigned CQ_EXT_DATA_W = 512;
  localparam int unsigned CQ_EXT_KEEP_W = CQ_EXT_DATA_W / 32;

  // One CQ beat as carried through the buffer.
  typedef struct packed {
    logic [CQ_EXT_DATA_W-1:0] tdata;
    logic [CQ_EXT_USER_W-1:0] tuser;
    logic                     tlast;
    logic [CQ_EXT_KEEP_W-1:0] tkeep;
  } cq_beat_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned clog2_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cpm_cq_beat_fifo.sv
// First-word-fall-through beat FIFO with wrap-bit pointers.
module cpm_cq_beat_fifo
  import cpm_ext_cq_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter type         beat_t = cq_beat_t,
  localparam int unsigned CW    = clog2_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  beat_t         wr_beat,
  input  logic          rd_en,
  output beat_t         rd_beat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] level
);

  localparam int unsigned AW = CW - 1;

  beat_t         mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_wr, do_rd;

  // Status flags and next-pointer computation; a pop frees the slot for a same-cycle push.
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    level    = wr_ptr_q - rd_ptr_q;
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + CW'(1) : rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_beat;
  end

  // Head is forced to zero when empty so idle outputs read as zero.
  assign rd_beat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pciea_ext_cq_credit_rx.sv
// Credit-based CQ receiver: buffers upstream beats, presents valid/ready downstream,
// returns one credit per freed slot.
module pciea_ext_cq_credit_rx
  import cpm_ext_cq_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned USER_WIDTH = CQ_EXT_USER_W,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 32
) (
  input  logic                           user_clk,
  input  logic                           user_reset,
  input  logic [DATA_WIDTH-1:0]          s_axis_cq_tdata,
  input  logic [USER_WIDTH-1:0]          s_axis_cq_tuser,
  input  logic                           s_axis_cq_tlast,
  input  logic [KEEP_WIDTH-1:0]          s_axis_cq_tkeep,
  input  logic                           s_axis_cq_tvalid,
  output logic                           s_axis_cq_credit,
  output logic [DATA_WIDTH-1:0]          m_axis_cq_tdata,
  output logic [USER_WIDTH-1:0]          m_axis_cq_tuser,
  output logic                           m_axis_cq_tlast,
  output logic [KEEP_WIDTH-1:0]          m_axis_cq_tkeep,
  output logic                           m_axis_cq_tvalid,
  input  logic                           m_axis_cq_tready,
  output logic [clog2_cnt_w(DEPTH)-1:0]  credit_outstanding,
  output logic [clog2_cnt_w(DEPTH)-1:0]  fifo_level,
  output logic                           err_overflow
);

  localparam int unsigned CW = clog2_cnt_w(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic [KEEP_WIDTH-1:0] tkeep;
  } beat_t;

  beat_t         wr_beat, rd_beat;
  logic          fifo_full, fifo_empty;
  logic          wr, pop, drop, issue;
  logic          credit_q, credit_d;
  logic          err_q, err_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] pending_q, pending_d;

  assign wr_beat = '{tdata: s_axis_cq_tdata, tuser: s_axis_cq_tuser,
                     tlast: s_axis_cq_tlast, tkeep: s_axis_cq_tkeep};

  cpm_cq_beat_fifo #(
    .DEPTH  (DEPTH),
    .beat_t (beat_t)
  ) u_fifo (
    .clk     (user_clk),
    .rst     (user_reset),
    .wr_en   (wr),
    .wr_beat (wr_beat),
    .rd_en   (m_axis_cq_tready),
    .rd_beat (rd_beat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign m_axis_cq_tvalid = !fifo_empty;
  assign m_axis_cq_tdata  = rd_beat.tdata;
  assign m_axis_cq_tuser  = rd_beat.tuser;
  assign m_axis_cq_tlast  = rd_beat.tlast;
  assign m_axis_cq_tkeep  = rd_beat.tkeep;

  assign s_axis_cq_credit   = credit_q;
  assign credit_outstanding = outstanding_q;
  assign err_overflow       = err_q;

  // Credit bookkeeping; a pop with nothing pending is returned the very next cycle.
  always_comb begin
    pop   = m_axis_cq_tvalid && m_axis_cq_tready;
    // The full term is redundant while the credit invariant holds; it keeps a
    // misbehaving peer from corrupting the buffer.
    drop  = s_axis_cq_tvalid && ((outstanding_q == '0) || (fifo_full && !pop));
    wr    = s_axis_cq_tvalid && !drop;
    issue = (pending_q != '0) || pop;
    credit_d      = issue;
    outstanding_d = outstanding_q + CW'(issue) - CW'(wr);
    pending_d     = pending_q + CW'(pop) - CW'(issue);
    err_d         = err_q || drop;
  end

  // Credit, counter and sticky error registers; reset re-arms the full advertisement.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      credit_q      <= 1'b0;
      err_q         <= 1'b0;
      outstanding_q <= '0;
      pending_q     <= CW'(DEPTH);
    end else begin
      credit_q      <= credit_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
      pending_q     <= pending_d;
    end
  end

endmodule

// File: tb/tb_pciea_ext_cq_credit_rx.sv
// Directed and randomised checks of the CQ credit receiver against a small credit model.
module tb_pciea_ext_cq_credit_rx;
  import cpm_ext_cq_pkg::*;

  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  cq_beat_t      drv;
  logic          s_axis_cq_tvalid;
  logic          s_axis_cq_credit;
  logic [511:0]  m_axis_cq_tdata;
  logic [228:0]  m_axis_cq_tuser;
  logic          m_axis_cq_tlast;
  logic [15:0]   m_axis_cq_tkeep;
  logic          m_axis_cq_tvalid;
  logic          m_axis_cq_tready;
  logic [4:0]    credit_outstanding;
  logic [4:0]    fifo_level;
  logic          err_overflow;

  always #5 clk = ~clk;

  pciea_ext_cq_credit_rx #(
    .DEPTH      (16),
    .DATA_WIDTH (512),
    .USER_WIDTH (229),
    .KEEP_WIDTH (16)
  ) dut (
    .user_clk           (clk),
    .user_reset         (rst),
    .s_axis_cq_tdata    (drv.tdata),
    .s_axis_cq_tuser    (drv.tuser),
    .s_axis_cq_tlast    (drv.tlast),
    .s_axis_cq_tkeep    (drv.tkeep),
    .s_axis_cq_tvalid   (s_axis_cq_tvalid),
    .s_axis_cq_credit   (s_axis_cq_credit),
    .m_axis_cq_tdata    (m_axis_cq_tdata),
    .m_axis_cq_tuser    (m_axis_cq_tuser),
    .m_axis_cq_tlast    (m_axis_cq_tlast),
    .m_axis_cq_tkeep    (m_axis_cq_tkeep),
    .m_axis_cq_tvalid   (m_axis_cq_tvalid),
    .m_axis_cq_tready   (m_axis_cq_tready),
    .credit_outstanding (credit_outstanding),
    .fifo_level         (fifo_level),
    .err_overflow       (err_overflow)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model of the receiver as seen from outside.
  int       m_out, m_level, m_pend, pulses;
  logic     m_err;
  cq_beat_t sb [$];

  task automatic check_eq(input string tag, input logic [767:0] got, input logic [767:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cq_beat_t rand_beat();
    cq_beat_t     b;
    logic [255:0] u;
    for (int i = 0; i < 16; i++) b.tdata[i*32 +: 32] = $urandom;
    for (int i = 0; i < 8; i++)  u[i*32 +: 32] = $urandom;
    b.tuser = u[228:0];
    b.tlast = 1'($urandom);
    b.tkeep = 16'($urandom);
    return b;
  endfunction

  task automatic model_reset();
    m_out   = 0;
    m_level = 0;
    m_pend  = DEPTH;
    m_err   = 1'b0;
    sb.delete();
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_eq({pfx, "_credit"}, s_axis_cq_credit, 0);
    check_eq({pfx, "_tvalid"}, m_axis_cq_tvalid, 0);
    check_eq({pfx, "_data"}, {m_axis_cq_tdata, m_axis_cq_tuser, m_axis_cq_tlast, m_axis_cq_tkeep}, 0);
    check_eq({pfx, "_outstanding"}, credit_outstanding, 0);
    check_eq({pfx, "_level"}, fifo_level, 0);
    check_eq({pfx, "_err"}, err_overflow, 0);
  endtask

  // Advance one clock with the inputs currently driven, then compare against the model.
  task automatic tick();
    logic wr, ovf, pop, cr;
    wr  = s_axis_cq_tvalid && (m_out > 0);
    ovf = s_axis_cq_tvalid && (m_out == 0);
    pop = (m_level > 0) && m_axis_cq_tready;
    cr  = (m_pend > 0) || pop;
    @(posedge clk);
    @(negedge clk);
    if (wr) begin
      sb.push_back(drv);
      m_out--;
      m_level++;
    end
    if (pop && sb.size() > 0) begin
      void'(sb.pop_front());
      m_level--;
      m_pend++;
    end
    if (cr) begin
      m_out++;
      m_pend--;
      pulses++;
    end
    if (ovf) m_err = 1'b1;
    check_eq("credit", s_axis_cq_credit, cr);
    check_eq("outstanding", credit_outstanding, m_out);
    check_eq("level", fifo_level, m_level);
    check_eq("err", err_overflow, m_err);
    check_eq("tvalid", m_axis_cq_tvalid, m_level > 0);
    if (m_level > 0 && sb.size() > 0)
      check_eq("head", {m_axis_cq_tdata, m_axis_cq_tuser, m_axis_cq_tlast, m_axis_cq_tkeep}, sb[0]);
    check_eq("invariant", int'(fifo_level) + int'(credit_outstanding) + m_pend, DEPTH);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    s_axis_cq_tvalid = 1'b0;
    m_axis_cq_tready = 1'b0;
    drv              = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("rst");
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    int sent, cyc;
    rst = 1'b1;
    s_axis_cq_tvalid = 1'b0;
    m_axis_cq_tready = 1'b0;
    drv = '0;

    // Reset release with no traffic: 16 consecutive credit pulses, then silence.
    do_reset();
    pulses = 0;
    repeat (20) tick();
    check_eq("t1_pulses", pulses, 16);
    check_eq("t1_outstanding", credit_outstanding, 16);

    // Single beat through with tready high.
    drv.tdata = {16{32'hA5A5_A5A5}};
    drv.tuser = 229'h1_2345_6789;
    drv.tlast = 1'b1;
    drv.tkeep = 16'hFFFF;
    s_axis_cq_tvalid = 1'b1;
    m_axis_cq_tready = 1'b1;
    tick();
    check_eq("t2_tvalid_n1", m_axis_cq_tvalid, 1);
    check_eq("t2_tdata", m_axis_cq_tdata, {16{32'hA5A5_A5A5}});
    s_axis_cq_tvalid = 1'b0;
    drv = '0;
    tick();
    check_eq("t2_credit_n2", s_axis_cq_credit, 1);
    repeat (3) tick();
    check_eq("t2_outstanding", credit_outstanding, 16);

    // Fill the buffer with tready low.
    m_axis_cq_tready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drv = rand_beat();
      s_axis_cq_tvalid = 1'b1;
      tick();
    end
    s_axis_cq_tvalid = 1'b0;
    check_eq("t3_level_full", fifo_level, 16);
    check_eq("t3_outstanding_zero", credit_outstanding, 0);
    check_eq("t3_no_credits", pulses, 0);

    // Beat without credit is dropped and flags the sticky error.
    drv = rand_beat();
    s_axis_cq_tvalid = 1'b1;
    tick();
    s_axis_cq_tvalid = 1'b0;
    check_eq("t3_err_set", err_overflow, 1);
    check_eq("t3_level_kept", fifo_level, 16);
    tick();
    check_eq("t3_err_sticky", err_overflow, 1);

    // Drain in order; each pop returns a credit the following cycle.
    m_axis_cq_tready = 1'b1;
    repeat (20) tick();
    check_eq("t3_drain_pulses", pulses, 16);
    check_eq("t3_drain_level", fifo_level, 0);
    check_eq("t3_drain_outstanding", credit_outstanding, 16);

    // Random traffic from a credit-respecting peer.
    do_reset();
    repeat (17) tick();
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      s_axis_cq_tvalid = ($urandom_range(1, 100) <= 50) && (m_out > 0);
      if (s_axis_cq_tvalid) begin
        drv = rand_beat();
        sent++;
      end
      m_axis_cq_tready = ($urandom_range(1, 100) <= 30);
      tick();
      cyc++;
    end
    check_eq("t4_budget", sent, 10000);
    s_axis_cq_tvalid = 1'b0;
    m_axis_cq_tready = 1'b1;
    repeat (40) tick();
    check_eq("t4_level", fifo_level, 0);
    check_eq("t4_no_overflow", err_overflow, 0);
    check_eq("t4_outstanding", credit_outstanding, 16);

    // Asynchronous reset with seven beats buffered.
    m_axis_cq_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drv = rand_beat();
      s_axis_cq_tvalid = 1'b1;
      tick();
    end
    s_axis_cq_tvalid = 1'b0;
    check_eq("t5_level7", fifo_level, 7);
    #2 rst = 1'b1;
    #1 check_zero_outputs("t5_async");
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    pulses = 0;
    repeat (18) tick();
    check_eq("t5_pulses", pulses, 16);
    check_eq("t5_level", fifo_level, 0);
    check_eq("t5_outstanding", credit_outstanding, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
